// File: rtl/lcd_pkg.sv
// Shared types and constants for the character LCD bus controller.
// Holds the state set, command codes, default timings and the long-command test.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    START,
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    WAIT,
    ACK
  } lcd_state_t;

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  localparam int T_PWRUP_DEF = 750000;
  localparam int T_CMD_DEF   = 2000;
  localparam int T_CLR_DEF   = 82000;
  localparam int E_W_DEF     = 12;
  localparam int CW_DEF      = 20;

  // Clear and home (8'h03 also decodes as home) need the long wait.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] dat
  );
    return !rs && (dat == CLEAR || dat == HOME || dat == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter shared by the power-up, E-pulse and execution waits.
// Ports: Clk, load/value (reload with count-1), done (counter at zero).
module lcd_delay_timer #(
  parameter int CW = 20
) (
  input  logic          Clk,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (load)
      cnt <= value;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 bus controller: power-up wait, init strobes, arbitrated pin timing.
// Ports: Clk/Reset, init port, user write port, LCD pins, Busy.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = T_PWRUP_DEF,
  parameter int T_CMD   = T_CMD_DEF,
  parameter int T_CLR   = T_CLR_DEF,
  parameter int E_W     = E_W_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       InitReq,
  input  logic [7:0] InitDato,
  input  logic       DoneInit,
  output logic       Comenzar,
  output logic       Cuenta,
  input  logic       WrValid,
  input  logic       WrRs,
  input  logic [7:0] WrData,
  output logic       WrReady,
  output logic       LcdE,
  output logic       LcdRs,
  output logic       LcdRw,
  output logic [7:0] LcdDb,
  output logic       Busy
);

  localparam logic [CW-1:0] PW_M1  = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] EW_M1  = CW'(E_W - 1);
  localparam logic [CW-1:0] CMD_M1 = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_M1 = CW'(T_CLR - 1);

  lcd_state_t    state;
  lcd_state_t    nxt;
  logic          is_init;
  logic          acc_init;
  logic          acc_user;
  logic          ld;
  logic [CW-1:0] ldv;
  logic          tdone;

  lcd_delay_timer #(
    .CW(CW)
  ) u_tmr (
    .Clk  (Clk),
    .load (ld),
    .value(ldv),
    .done (tdone)
  );

  // Timer loads on the edge that enters a counted state.
  always_comb begin
    nxt      = state;
    ld       = 1'b0;
    ldv      = '0;
    acc_init = 1'b0;
    acc_user = 1'b0;
    if (Reset) begin
      nxt = PWRUP;
      ld  = 1'b1;
      ldv = PW_M1;
    end else begin
      unique case (state)
        PWRUP: if (tdone) nxt = START;
        START: nxt = IDLE;
        IDLE: begin
          if (InitReq) begin
            acc_init = 1'b1;
            nxt      = SETUP;
          end else if (WrReady && WrValid) begin
            acc_user = 1'b1;
            nxt      = SETUP;
          end
        end
        SETUP: begin
          nxt = EHIGH;
          ld  = 1'b1;
          ldv = EW_M1;
        end
        EHIGH: if (tdone) nxt = HOLD;
        HOLD: begin
          nxt = WAIT;
          ld  = 1'b1;
          ldv = is_long_cmd(LcdRs, LcdDb) ? CLR_M1 : CMD_M1;
        end
        WAIT: if (tdone) nxt = ACK;
        ACK: nxt = IDLE;
        default: nxt = PWRUP;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= PWRUP;
      is_init  <= 1'b0;
      LcdE     <= 1'b0;
      LcdRs    <= 1'b0;
      LcdDb    <= 8'h00;
      Comenzar <= 1'b0;
      Cuenta   <= 1'b0;
      WrReady  <= 1'b0;
      Busy     <= 1'b1;
    end else begin
      state    <= nxt;
      LcdE     <= (nxt == EHIGH);
      Busy     <= (nxt != IDLE);
      Cuenta   <= (nxt == START) ||
                  (nxt == ACK && is_init);
      Comenzar <= Comenzar || (nxt == START);
      WrReady  <= (nxt == IDLE) && DoneInit &&
                  !InitReq;
      if (acc_init) begin
        is_init <= 1'b1;
        LcdRs   <= 1'b0;
        LcdDb   <= InitDato;
      end else if (acc_user) begin
        is_init <= 1'b0;
        LcdRs   <= WrRs;
        LcdDb   <= WrData;
      end
    end
  end

  assign LcdRw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Randomized self-checking bench for lcd_bus_ctrl with a stub init sequencer.
// Bus transfers are captured at E fall and compared with an expected queue.
module tb_lcd_bus_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_CMD   = 5;
  localparam int T_CLR   = 9;
  localparam int E_W     = 3;
  localparam int CW      = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       InitReq;
  logic [7:0] InitDato;
  logic       DoneInit;
  logic       Comenzar;
  logic       Cuenta;
  logic       WrValid = 1'b0;
  logic       WrRs = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic       WrReady;
  logic       LcdE;
  logic       LcdRs;
  logic       LcdRw;
  logic [7:0] LcdDb;
  logic       Busy;

  lcd_bus_ctrl #(
    .T_PWRUP(T_PWRUP),
    .T_CMD  (T_CMD),
    .T_CLR  (T_CLR),
    .E_W    (E_W),
    .CW     (CW)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .InitReq (InitReq),
    .InitDato(InitDato),
    .DoneInit(DoneInit),
    .Comenzar(Comenzar),
    .Cuenta  (Cuenta),
    .WrValid (WrValid),
    .WrRs    (WrRs),
    .WrData  (WrData),
    .WrReady (WrReady),
    .LcdE    (LcdE),
    .LcdRs   (LcdRs),
    .LcdRw   (LcdRw),
    .LcdDb   (LcdDb),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Stub init sequencer: advances on the falling edge inside a Cuenta cycle.
  logic [7:0] init_cmds [5];
  int         iidx;
  initial begin
    init_cmds[0] = 8'h38;
    init_cmds[1] = 8'h0F;
    init_cmds[2] = 8'h01;
    init_cmds[3] = 8'h06;
    init_cmds[4] = 8'h80;
  end

  always @(negedge Clk) begin
    if (Reset) begin
      InitReq  <= 1'b0;
      InitDato <= 8'h00;
      DoneInit <= 1'b0;
      iidx     <= 0;
    end else if (Cuenta && Comenzar) begin
      if (iidx < 5) begin
        InitReq  <= 1'b1;
        InitDato <= init_cmds[iidx];
        iidx     <= iidx + 1;
      end else begin
        InitReq  <= 1'b0;
        DoneInit <= 1'b1;
      end
    end
  end

  // Bus monitor.
  int   obs_db [$];
  int   obs_rs [$];
  int   obs_ew [$];
  int   obs_bl [$];
  int   exp_q  [$];
  int   e_len, b_len, n_cuenta;
  int   n_dbl = 0;
  int   n_early = 0;
  logic prev_e, prev_b, prev_c, saw_e;

  always @(negedge Clk) begin
    if (Reset) begin
      obs_db.delete();
      obs_rs.delete();
      obs_ew.delete();
      obs_bl.delete();
      e_len    = 0;
      b_len    = 0;
      n_cuenta = 0;
      prev_e   = 1'b0;
      prev_b   = 1'b1;
      prev_c   = 1'b0;
      saw_e    = 1'b0;
    end else begin
      if (LcdE) e_len++;
      if (prev_e && !LcdE) begin
        obs_db.push_back(int'(LcdDb));
        obs_rs.push_back(int'(LcdRs));
        obs_ew.push_back(e_len);
        e_len = 0;
        saw_e = 1'b1;
      end
      if (Busy) b_len++;
      else if (prev_b) begin
        if (saw_e) obs_bl.push_back(b_len);
        b_len = 0;
        saw_e = 1'b0;
      end
      if (Cuenta) n_cuenta++;
      if (Cuenta && prev_c) n_dbl++;
      if (!DoneInit && WrReady) n_early++;
      prev_e = LcdE;
      prev_b = Busy;
      prev_c = Cuenta;
    end
  end

  // Expected busy span of one transfer from the accept edge.
  function automatic int xfer_len(input int e);
    int rs, d, dly;
    rs  = (e >> 8) & 1;
    d   = e & 255;
    dly = (rs == 0 && d >= 1 && d <= 3) ? T_CLR : T_CMD;
    return 1 + E_W + 1 + dly + 1;
  endfunction

  task automatic do_reset();
    int k;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_e", LcdE, 0);
    chk("rst_rs", LcdRs, 0);
    chk("rst_rw", LcdRw, 0);
    chk("rst_db", LcdDb, 0);
    chk("rst_com", Comenzar, 0);
    chk("rst_cnt", Cuenta, 0);
    chk("rst_rdy", WrReady, 0);
    chk("rst_busy", Busy, 1);
    exp_q.delete();
    for (int i = 0; i < 5; i++)
      exp_q.push_back(int'(init_cmds[i]));
    Reset = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(posedge Clk);
      #1;
      if (Cuenta) break;
    end
    chk("first_cuenta", k, T_PWRUP);
    chk("comenzar", Comenzar, 1);
    @(posedge Clk);
    #1;
    chk("init_left_idle", InitReq, 1);
    chk("cuenta_one", Cuenta, 0);
  endtask

  task automatic user_write(input logic rs, input logic [7:0] d);
    int k;
    WrValid = 1'b1;
    WrRs    = rs;
    WrData  = d;
    for (k = 0; k < 3000; k++) begin
      @(negedge Clk);
      if (WrReady) break;
    end
    chk("wr_ready", WrReady, 1);
    @(posedge Clk);
    #1;
    WrValid = 1'b0;
    WrRs    = 1'($urandom);
    WrData  = 8'($urandom);
    exp_q.push_back({23'd0, rs, d});
  endtask

  task automatic compare_all();
    int n;
    for (int k = 0; k < 5000; k++) begin
      @(negedge Clk);
      if (!Busy && obs_bl.size() >= exp_q.size()) break;
    end
    @(posedge Clk);
    #1;
    chk("n_xfer", obs_bl.size(), exp_q.size());
    chk("n_efall", obs_db.size(), exp_q.size());
    n = exp_q.size();
    if (obs_db.size() < n) n = obs_db.size();
    if (obs_bl.size() < n) n = obs_bl.size();
    for (int i = 0; i < n; i++) begin
      chk("db", obs_db[i], exp_q[i] & 255);
      chk("rs", obs_rs[i], (exp_q[i] >> 8) & 1);
      chk("e_width", obs_ew[i], E_W);
      chk("xfer_len", obs_bl[i], xfer_len(exp_q[i]));
    end
    if (exp_q.size() > 0) begin
      chk("db_hold", LcdDb, exp_q[$] & 255);
      chk("rs_hold", LcdRs, (exp_q[$] >> 8) & 1);
    end
    chk("rw_low", LcdRw, 0);
    chk("busy_idle", Busy, 0);
    obs_db.delete();
    obs_rs.delete();
    obs_ew.delete();
    obs_bl.delete();
    exp_q.delete();
  endtask

  initial begin
    int c0;
    logic       rs;
    logic [7:0] d;

    // Init with a user write already pending.
    do_reset();
    user_write(1'b1, 8'h41);
    compare_all();
    chk("early_ready", n_early, 0);
    chk("cuenta_total", n_cuenta, 6);
    chk("done_init", DoneInit, 1);

    // Back-to-back user writes.
    c0 = n_cuenta;
    user_write(1'b0, 8'h01);
    user_write(1'b1, 8'h48);
    compare_all();
    chk("user_no_cuenta", n_cuenta, c0);

    // Random user traffic.
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        d = 8'($urandom_range(1, 3));
      else
        d = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(posedge Clk);
      #1;
      user_write(rs, d);
    end
    compare_all();
    chk("rand_no_cuenta", n_cuenta, c0);

    // Reset in the middle of an E pulse.
    user_write(1'b1, 8'h5A);
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (LcdE) break;
    end
    chk("e_seen", LcdE, 1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("mid_rst_e", LcdE, 0);
    chk("mid_rst_busy", Busy, 1);
    chk("mid_rst_cnt", Cuenta, 0);
    chk("mid_rst_com", Comenzar, 0);
    chk("mid_rst_db", LcdDb, 0);
    do_reset();
    compare_all();
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (DoneInit) break;
    end
    @(posedge Clk);
    #1;
    chk("re_done", DoneInit, 1);
    chk("re_cuenta_total", n_cuenta, 6);
    chk("no_double_cuenta", n_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
